// File: rtl/npc_mem_responder_if.sv
// Valid/ready request/response bundle between the npc load/store path (master)
// and the data-memory responder (slave).
interface npc_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_size, req_signed, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_size, req_signed, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/npc_mem_responder.sv
// Fixed-latency data-memory responder: word-organised SRAM at BASE with
// little-endian byte/half/word access, load extension and fault reporting.
module npc_mem_responder #(
    parameter int          ADDR_W  = 12,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,
    npc_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [32:0] BASE33     = {1'b0, BASE};
    localparam logic [32:0] LIMIT33    = BASE33 + (33'd4 << ADDR_W);
    localparam logic [3:0]  COUNT_INIT = 4'(LATENCY - 1);

    state_t      state;
    logic [3:0]  count;
    logic        ready_q;
    logic        valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        lat_wen;
    logic [31:0] lat_addr;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [31:0] lat_wdata;

    logic [31:0] mem [2**ADDR_W];

    logic [32:0]       addr33;
    logic [31:0]       offset;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic              fault;
    logic [31:0]       stored;
    logic [31:0]       shifted;
    logic [31:0]       load_data;
    logic [3:0]        byte_en;
    logic [31:0]       store_word;
    logic              commit;
    logic              mem_write;

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // Everything below decodes the latched request, never the live bus inputs.
    always_comb begin
        addr33   = {1'b0, lat_addr};
        offset   = lat_addr - BASE;
        word_idx = ADDR_W'(offset >> 2);
        lane     = lat_addr[1:0];
        fault    = (lat_size == 2'd3)
                || (lat_size == 2'd1 && lat_addr[0])
                || (lat_size == 2'd2 && lat_addr[1:0] != 2'd0)
                || (addr33 < BASE33)
                || (addr33 >= LIMIT33);
        stored   = mem[word_idx];
        shifted  = stored >> {lane, 3'b000};

        load_data = shifted;
        unique case (lat_size)
            2'd0:    load_data = lat_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                            : {24'h0, shifted[7:0]};
            2'd1:    load_data = lat_signed ? {{16{shifted[15]}}, shifted[15:0]}
                                            : {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase

        byte_en = 4'b1111;
        unique case (lat_size)
            2'd0:    byte_en = 4'b0001 << lane;
            2'd1:    byte_en = 4'b0011 << lane;
            default: byte_en = 4'b1111;
        endcase

        store_word = lat_wdata << {lane, 3'b000};
        commit     = (state == BUSY) && (count == 4'd0);
        mem_write  = commit && lat_wen && !fault;
    end

    // Storage has no reset; an async reset forces IDLE, so no commit can fire.
    always_ff @(posedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            lat_wen    <= 1'b0;
            lat_addr   <= 32'h0;
            lat_size   <= 2'd0;
            lat_signed <= 1'b0;
            lat_wdata  <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (bus.req_valid && ready_q) begin
                        lat_wen    <= bus.req_wen;
                        lat_addr   <= bus.req_addr;
                        lat_size   <= bus.req_size;
                        lat_signed <= bus.req_signed;
                        lat_wdata  <= bus.req_wdata;
                        count      <= COUNT_INIT;
                        ready_q    <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (count == 4'd0) begin
                        valid_q <= 1'b1;
                        err_q   <= fault;
                        rdata_q <= (fault || lat_wen) ? 32'h0 : load_data;
                        state   <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        valid_q <= 1'b0;
                        rdata_q <= 32'h0;
                        err_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_npc_mem_responder.sv
// Self-checking bench: byte-level memory model with cycle-accurate handshake
// expectations for a LATENCY=2 instance, plus directed checks on a LATENCY=1 instance.
module tb_npc_mem_responder;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam longint      BASE_L = 64'h8000_0000;
    localparam int          WORDS  = 4096;
    localparam int          LAT    = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    npc_mem_responder_if bus ();
    npc_mem_responder_if bus1 ();

    npc_mem_responder #(.ADDR_W(12), .BASE(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    npc_mem_responder #(.ADDR_W(12), .BASE(BASE), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  bmem [0:4*WORDS-1];
    bit          m_ready = 1'b0;
    bit          m_valid = 1'b0;
    int          m_wait  = 0;
    logic [31:0] m_rdata = 32'h0;
    bit          m_err   = 1'b0;
    bit          p_wen;
    logic [31:0] p_addr;
    logic [1:0]  p_size;
    bit          p_sgn;
    logic [31:0] p_wdata;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Performs the pending access on the byte-array model at its commit edge.
    function automatic void model_commit();
        longint      a;
        int          nb;
        int          off;
        bit          fault;
        logic [31:0] v;
        a     = {32'h0, p_addr};
        nb    = 1 << p_size;
        fault = (p_size == 2'd3) || (p_size == 2'd1 && p_addr[0])
             || (p_size == 2'd2 && p_addr[1:0] != 2'd0)
             || (a < BASE_L) || (a >= BASE_L + 4 * WORDS);
        m_rdata = 32'h0;
        m_err   = fault;
        if (fault) return;
        off = int'(a - BASE_L);
        if (p_wen) begin
            for (int i = 0; i < nb; i++) bmem[off + i] = p_wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = bmem[off + i];
            if (p_sgn && nb < 4 && v[8*nb - 1]) begin
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            m_rdata = v;
        end
    endfunction

    // Check the current cycle, then predict what the next rising edge produces.
    always @(negedge clk) begin
        if (reset) begin
            checkOutput("rst_req_ready",  32'(bus.req_ready), 32'h0);
            checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
            checkOutput("rst_resp_rdata", bus.resp_rdata, 32'h0);
            checkOutput("rst_resp_err",   32'(bus.resp_err), 32'h0);
            m_ready = 1'b0;
            m_valid = 1'b0;
            m_wait  = 0;
        end else begin
            checkOutput("req_ready",  32'(bus.req_ready), 32'(m_ready));
            checkOutput("resp_valid", 32'(bus.resp_valid), 32'(m_valid));
            if (m_valid) begin
                checkOutput("resp_rdata", bus.resp_rdata, m_rdata);
                checkOutput("resp_err",   32'(bus.resp_err), 32'(m_err));
            end
            if (m_ready) begin
                if (bus.req_valid) begin
                    p_wen   = bus.req_wen;
                    p_addr  = bus.req_addr;
                    p_size  = bus.req_size;
                    p_sgn   = bus.req_signed;
                    p_wdata = bus.req_wdata;
                    m_ready = 1'b0;
                    m_wait  = LAT;
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    model_commit();
                    m_valid = 1'b1;
                end
            end else if (m_valid) begin
                if (bus.resp_ready) begin
                    m_valid = 1'b0;
                    m_ready = 1'b1;
                end
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    // Issues one request on the LATENCY=2 port; entered and left just after a rising edge.
    task automatic applyStimulus(input bit wen, input logic [31:0] addr, input logic [1:0] size,
                                 input bit sgn, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err, output int lat);
        bit done;
        bus.req_wen    = wen;
        bus.req_addr   = addr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.req_ready) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("[TB] FAIL accept_timeout: got no req_ready, expected req_ready=1");
        end
        @(posedge clk) #1;
        bus.req_valid = 1'b0;
        done  = 1'b0;
        rdata = 32'hx;
        err   = 1'bx;
        lat   = -1;
        for (int i = 1; i <= 50 && !done; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                done  = 1'b1;
                rdata = bus.resp_rdata;
                err   = bus.resp_err;
                lat   = i - 1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("[TB] FAIL resp_timeout: got no resp_valid, expected resp_valid=1");
        end
        @(posedge clk) #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lt;
    bit          seen;

    initial begin
        bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = 32'h0; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_wen = 1'b0; bus1.req_addr = 32'h0; bus1.req_size = 2'd0;
        bus1.req_signed = 1'b0; bus1.req_wdata = 32'h0; bus1.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk) #1;

        // word round-trip with latency measurement
        applyStimulus(1, BASE, 2'd2, 0, 32'h1122_3344, rd, er, lt);
        checkOutput("store_w_err", 32'(er), 32'h0);
        checkOutput("store_w_lat", 32'(lt), 32'd2);
        applyStimulus(0, BASE, 2'd2, 0, 32'h0, rd, er, lt);
        checkOutput("load_w_data", rd, 32'h1122_3344);
        checkOutput("load_w_lat",  32'(lt), 32'd2);

        // byte lane steering and extension
        applyStimulus(1, BASE + 1, 2'd0, 0, 32'h0000_00AB, rd, er, lt);
        applyStimulus(0, BASE, 2'd2, 0, 32'h0, rd, er, lt);
        checkOutput("byte_merge", rd, 32'h1122_AB44);
        applyStimulus(0, BASE + 1, 2'd0, 1, 32'h0, rd, er, lt);
        checkOutput("lb_signed", rd, 32'hFFFF_FFAB);
        applyStimulus(0, BASE + 1, 2'd0, 0, 32'h0, rd, er, lt);
        checkOutput("lb_unsigned", rd, 32'h0000_00AB);

        // half-word into the upper half of a zeroed word
        applyStimulus(1, BASE + 4, 2'd2, 0, 32'h0, rd, er, lt);
        applyStimulus(1, BASE + 6, 2'd1, 0, 32'h0000_8001, rd, er, lt);
        applyStimulus(0, BASE + 4, 2'd2, 0, 32'h0, rd, er, lt);
        checkOutput("half_merge", rd, 32'h8001_0000);
        applyStimulus(0, BASE + 6, 2'd1, 1, 32'h0, rd, er, lt);
        checkOutput("lh_signed", rd, 32'hFFFF_8001);

        // faults and range boundaries
        applyStimulus(0, BASE + 2, 2'd2, 0, 32'h0, rd, er, lt);
        checkOutput("misalign_err", 32'(er), 32'h1);
        checkOutput("misalign_data", rd, 32'h0);
        applyStimulus(1, 32'h7FFF_FFFC, 2'd2, 0, 32'h5555_5555, rd, er, lt);
        checkOutput("below_base_err", 32'(er), 32'h1);
        applyStimulus(1, BASE + 32'h4000, 2'd2, 0, 32'h6666_6666, rd, er, lt);
        checkOutput("past_top_err", 32'(er), 32'h1);
        applyStimulus(0, BASE, 2'd3, 0, 32'h0, rd, er, lt);
        checkOutput("size3_err", 32'(er), 32'h1);
        applyStimulus(1, BASE + 32'h3FFC, 2'd2, 0, 32'hA5A5_0F0F, rd, er, lt);
        checkOutput("last_word_err", 32'(er), 32'h0);
        applyStimulus(0, BASE + 32'h3FFF, 2'd0, 0, 32'h0, rd, er, lt);
        checkOutput("last_byte", rd, 32'h0000_00A5);
        applyStimulus(0, BASE, 2'd2, 0, 32'h0, rd, er, lt);
        checkOutput("after_faults", rd, 32'h1122_AB44);

        // backpressure with a second request held on the bus
        bus.resp_ready = 1'b0;
        bus.req_wen = 1'b0; bus.req_addr = BASE + 4; bus.req_size = 2'd2; bus.req_signed = 1'b0;
        bus.req_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.req_ready) seen = 1'b1;
        end
        checkOutput("bp_accept", 32'(seen), 32'h1);
        @(posedge clk) #1;
        bus.req_addr = BASE + 6; bus.req_size = 2'd1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        checkOutput("bp_resp_seen", 32'(seen), 32'h1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", 32'(bus.resp_valid), 32'h1);
            checkOutput("bp_hold_rdata", bus.resp_rdata, 32'h8001_0000);
            checkOutput("bp_hold_ready", 32'(bus.req_ready), 32'h0);
        end
        @(posedge clk) #1;
        bus.resp_ready = 1'b1;
        @(posedge clk) #1;
        @(negedge clk);
        checkOutput("bp_idle_ready", 32'(bus.req_ready), 32'h1);
        checkOutput("bp_idle_valid", 32'(bus.resp_valid), 32'h0);
        @(posedge clk) #1;
        bus.req_valid = 1'b0;
        seen = 1'b0;
        rd = 32'hx;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin seen = 1'b1; rd = bus.resp_rdata; end
        end
        checkOutput("bp_pending_data", rd, 32'h0000_8001);
        @(posedge clk) #1;

        // reset while a store is still counting down
        bus.req_wen = 1'b1; bus.req_addr = BASE; bus.req_size = 2'd2; bus.req_wdata = 32'hDEAD_BEEF;
        bus.req_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.req_ready) seen = 1'b1;
        end
        @(posedge clk) #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk) #1;
        applyStimulus(0, BASE, 2'd2, 0, 32'h0, rd, er, lt);
        checkOutput("reset_no_commit", rd, 32'h1122_AB44);

        // LATENCY=1 instance: response one cycle after acceptance
        bus1.req_wen = 1'b1; bus1.req_addr = BASE + 16; bus1.req_size = 2'd2;
        bus1.req_wdata = 32'hCAFE_BABE; bus1.req_valid = 1'b1;
        @(negedge clk);
        checkOutput("l1_ready", 32'(bus1.req_ready), 32'h1);
        @(posedge clk) #1;
        bus1.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("l1_store_not_yet", 32'(bus1.resp_valid), 32'h0);
        @(negedge clk);
        checkOutput("l1_store_valid", 32'(bus1.resp_valid), 32'h1);
        checkOutput("l1_store_err", 32'(bus1.resp_err), 32'h0);
        @(posedge clk) #1;
        bus1.req_wen = 1'b0; bus1.req_valid = 1'b1;
        @(negedge clk);
        checkOutput("l1_ready2", 32'(bus1.req_ready), 32'h1);
        @(posedge clk) #1;
        bus1.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("l1_load_not_yet", 32'(bus1.resp_valid), 32'h0);
        @(negedge clk);
        checkOutput("l1_load_valid", 32'(bus1.resp_valid), 32'h1);
        checkOutput("l1_load_data", bus1.resp_rdata, 32'hCAFE_BABE);
        @(posedge clk) #1;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
